// File: rtl/multiword_adder_seq_if.sv
`default_nettype none
// ============================================================================
// multiword_adder_seq_if : operand load / control / result readback bundle
// Rev 1.0
// ============================================================================
interface multiword_adder_seq_if #(
  parameter int WORD_W    = 32,
  parameter int NUM_WORDS = 2
);
  localparam int IDX_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

  logic              i_wr_valid;
  logic              i_wr_opnd;
  logic [IDX_W-1:0]  i_wr_idx;
  logic [WORD_W-1:0] i_wr_data;
  logic              i_start;
  logic              i_mode_sub;
  logic              i_cin;
  logic [IDX_W-1:0]  i_rd_idx;
  logic [WORD_W-1:0] o_rd_data;
  logic              o_busy;
  logic              o_done;
  logic              o_cout;
  logic              o_overflow;

  modport slave (
    input  i_wr_valid, i_wr_opnd, i_wr_idx, i_wr_data,
    input  i_start, i_mode_sub, i_cin, i_rd_idx,
    output o_rd_data, o_busy, o_done, o_cout, o_overflow
  );

  modport master (
    output i_wr_valid, i_wr_opnd, i_wr_idx, i_wr_data,
    output i_start, i_mode_sub, i_cin, i_rd_idx,
    input  o_rd_data, o_busy, o_done, o_cout, o_overflow
  );
endinterface
`default_nettype wire

// File: rtl/multiword_adder_seq.sv
`default_nettype none
// ============================================================================
// multiword_adder_seq : word-serial multi-precision adder/subtractor
// Rev 1.0
// ============================================================================
module multiword_adder_seq #(
  parameter int WORD_W    = 32,
  parameter int NUM_WORDS = 2
) (
  input  logic                 clk,
  input  logic                 resetn,
  multiword_adder_seq_if.slave bus
);
  localparam int IDX_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam logic [IDX_W-1:0] c_LAST_IDX = IDX_W'(NUM_WORDS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;

  logic [WORD_W-1:0] r_a   [NUM_WORDS];
  logic [WORD_W-1:0] r_b   [NUM_WORDS];
  logic [WORD_W-1:0] r_res [NUM_WORDS];
  logic [IDX_W-1:0]  r_cnt;
  logic              r_mode;
  logic              r_carry;
  logic              r_cout;
  logic              r_ovf;

  logic              w_busy;
  logic              w_done;
  logic              w_start;
  logic              w_run;
  logic              w_last;
  logic              w_wr_ok;
  logic              w_rd_ok;
  logic [WORD_W-1:0] w_a;
  logic [WORD_W-1:0] w_bx;
  logic [WORD_W:0]   w_sum;

  // Range checks only exist when the index field can encode past the last word.
  generate
    if (NUM_WORDS == (1 << IDX_W)) begin : g_full_idx
      assign w_wr_ok = 1'b1;
      assign w_rd_ok = 1'b1;
    end else begin : g_part_idx
      localparam logic [IDX_W:0] c_NUM_WORDS = (IDX_W + 1)'(NUM_WORDS);
      assign w_wr_ok = ({1'b0, bus.i_wr_idx} < c_NUM_WORDS);
      assign w_rd_ok = ({1'b0, bus.i_rd_idx} < c_NUM_WORDS);
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_busy      = 1'b1;
    w_done      = 1'b0;
    w_start     = 1'b0;
    w_run       = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_busy  = 1'b0;
        w_start = bus.i_start;
        if (bus.i_start) begin
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        w_run = 1'b1;
        if (w_last) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        w_done      = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_busy      = 1'b0;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign w_last = (r_cnt == c_LAST_IDX);
  assign w_a    = r_a[r_cnt];
  assign w_bx   = r_mode ? ~r_b[r_cnt] : r_b[r_cnt];
  assign w_sum  = {1'b0, w_a} + {1'b0, w_bx} + {{WORD_W{1'b0}}, r_carry};

  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int k = 0; k < NUM_WORDS; k++) begin
        r_a[k]   <= '0;
        r_b[k]   <= '0;
        r_res[k] <= '0;
      end
      r_cnt   <= '0;
      r_mode  <= 1'b0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      if (!w_busy && bus.i_wr_valid && w_wr_ok) begin
        if (bus.i_wr_opnd) begin
          r_b[bus.i_wr_idx] <= bus.i_wr_data;
        end else begin
          r_a[bus.i_wr_idx] <= bus.i_wr_data;
        end
      end

      // Subtraction is A + ~B + ~borrow, so the incoming borrow is inverted here.
      if (w_start) begin
        r_mode  <= bus.i_mode_sub;
        r_carry <= bus.i_mode_sub ^ bus.i_cin;
        r_cnt   <= '0;
        r_cout  <= 1'b0;
        r_ovf   <= 1'b0;
      end

      if (w_run) begin
        r_res[r_cnt] <= w_sum[WORD_W-1:0];
        r_carry      <= w_sum[WORD_W];
        r_cnt        <= w_last ? '0 : r_cnt + 1'b1;
        if (w_last) begin
          r_cout <= w_sum[WORD_W];
          r_ovf  <= (w_a[WORD_W-1] == w_bx[WORD_W-1]) &&
                    (w_sum[WORD_W-1] != w_a[WORD_W-1]);
        end
      end
    end
  end

  assign bus.o_rd_data  = w_rd_ok ? r_res[bus.i_rd_idx] : '0;
  assign bus.o_busy     = w_busy;
  assign bus.o_done     = w_done;
  assign bus.o_cout     = r_cout;
  assign bus.o_overflow = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_multiword_adder_seq.sv
`default_nettype none
// ============================================================================
// tb_multiword_adder_seq : directed + random checks against a wide-integer model
// Rev 1.0
// ============================================================================
module tb_multiword_adder_seq;
  localparam int W0 = 32;
  localparam int N0 = 2;
  localparam int W1 = 8;
  localparam int N1 = 3;

  logic clk = 1'b0;
  logic resetn;
  int   n_chk = 0;
  int   n_err = 0;

  multiword_adder_seq_if #(.WORD_W(W0), .NUM_WORDS(N0)) bus0 ();
  multiword_adder_seq_if #(.WORD_W(W1), .NUM_WORDS(N1)) bus1 ();

  multiword_adder_seq #(.WORD_W(W0), .NUM_WORDS(N0)) dut0 (
    .clk(clk), .resetn(resetn), .bus(bus0)
  );
  multiword_adder_seq #(.WORD_W(W1), .NUM_WORDS(N1)) dut1 (
    .clk(clk), .resetn(resetn), .bus(bus1)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Full-width arithmetic reference: unsigned result/carry plus true signed range test.
  function automatic void model(input logic [127:0] a, input logic [127:0] b,
                                input bit sub, input bit cin, input int w,
                                output logic [127:0] res, output bit cout, output bit ovf);
    logic [127:0]        mask, full;
    logic signed [127:0] sa, sb, tv, lim;
    mask = (128'd1 << w) - 128'd1;
    if (!sub) begin
      full = a + b + 128'(cin);
      res  = full & mask;
      cout = full[w];
    end else begin
      res  = (a - b - 128'(cin)) & mask;
      cout = (a >= (b + 128'(cin)));
    end
    sa  = a[w-1] ? $signed(a | ~mask) : $signed(a);
    sb  = b[w-1] ? $signed(b | ~mask) : $signed(b);
    tv  = sub ? (sa - sb - $signed(128'(cin))) : (sa + sb + $signed(128'(cin)));
    lim = $signed(128'd1 << (w - 1));
    ovf = (tv >= lim) || (tv < -lim);
  endfunction

  task automatic load0(input logic [63:0] a, input logic [63:0] b);
    for (int k = 0; k < N0; k++) begin
      bus0.i_wr_valid = 1'b1;
      bus0.i_wr_opnd  = 1'b0;
      bus0.i_wr_idx   = 1'(k);
      bus0.i_wr_data  = a[k*W0 +: W0];
      step();
      if (k < N0 - 1) begin
        bus0.i_wr_opnd = 1'b1;
        bus0.i_wr_data = b[k*W0 +: W0];
        step();
      end
    end
    bus0.i_wr_valid = 1'b0;
  endtask

  // Top word of B is written in the start cycle itself.
  task automatic exec0(input logic [63:0] a, input logic [63:0] b, input bit sub,
                       input bit cin, input bit disturb, input string tag);
    logic [127:0] er;
    bit           ec, eo, bdone;
    int           ndone, dcyc;
    model({64'd0, a}, {64'd0, b}, sub, cin, W0 * N0, er, ec, eo);
    bus0.i_wr_valid = 1'b1;
    bus0.i_wr_opnd  = 1'b1;
    bus0.i_wr_idx   = 1'(N0 - 1);
    bus0.i_wr_data  = b[(N0-1)*W0 +: W0];
    bus0.i_start    = 1'b1;
    bus0.i_mode_sub = sub;
    bus0.i_cin      = cin;
    step();
    bus0.i_mode_sub = ~sub;
    bus0.i_cin      = ~cin;
    if (disturb) begin
      bus0.i_wr_valid = 1'b1;
      bus0.i_wr_opnd  = 1'b1;
      bus0.i_wr_idx   = 1'b0;
      bus0.i_wr_data  = 32'h55;
      bus0.i_start    = 1'b1;
    end else begin
      bus0.i_wr_valid = 1'b0;
      bus0.i_start    = 1'b0;
    end
    ndone = 0;
    dcyc  = -1;
    bdone = 1'b0;
    for (int c = 1; c <= N0 + 5; c++) begin
      if (bus0.o_done) begin
        ndone++;
        if (dcyc < 0) begin
          dcyc  = c;
          bdone = bus0.o_busy;
        end
      end
      step();
      bus0.i_wr_valid = 1'b0;
      bus0.i_start    = 1'b0;
    end
    chk({tag, "_done_count"}, 128'(ndone), 128'd1);
    chk({tag, "_done_latency"}, 128'(dcyc), 128'(N0 + 1));
    chk({tag, "_busy_at_done"}, 128'(bdone), 128'd1);
    chk({tag, "_busy_after"}, 128'(bus0.o_busy), 128'd0);
    for (int k = 0; k < N0; k++) begin
      bus0.i_rd_idx = 1'(k);
      #1;
      chk({tag, "_res_word"}, 128'(bus0.o_rd_data), 128'(er[k*W0 +: W0]));
    end
    chk({tag, "_cout"}, 128'(bus0.o_cout), 128'(ec));
    chk({tag, "_ovf"}, 128'(bus0.o_overflow), 128'(eo));
  endtask

  task automatic run1(input logic [23:0] a, input logic [23:0] b, input bit sub,
                      input bit cin, input string tag);
    logic [127:0] er;
    bit           ec, eo;
    int           cyc;
    model({104'd0, a}, {104'd0, b}, sub, cin, W1 * N1, er, ec, eo);
    for (int k = 0; k < N1; k++) begin
      bus1.i_wr_valid = 1'b1;
      bus1.i_wr_opnd  = 1'b0;
      bus1.i_wr_idx   = 2'(k);
      bus1.i_wr_data  = a[k*W1 +: W1];
      step();
      bus1.i_wr_opnd  = 1'b1;
      bus1.i_wr_data  = b[k*W1 +: W1];
      step();
    end
    bus1.i_wr_idx  = 2'd3;
    bus1.i_wr_data = 8'hFF;
    step();
    bus1.i_wr_opnd = 1'b0;
    step();
    bus1.i_wr_valid = 1'b0;
    bus1.i_start    = 1'b1;
    bus1.i_mode_sub = sub;
    bus1.i_cin      = cin;
    step();
    bus1.i_start = 1'b0;
    cyc = 1;
    while (!bus1.o_done && cyc < 20) begin
      step();
      cyc++;
    end
    chk({tag, "_latency"}, 128'(cyc), 128'(N1 + 1));
    step();
    for (int k = 0; k < N1; k++) begin
      bus1.i_rd_idx = 2'(k);
      #1;
      chk({tag, "_res_word"}, 128'(bus1.o_rd_data), 128'(er[k*W1 +: W1]));
    end
    bus1.i_rd_idx = 2'd3;
    #1;
    chk({tag, "_rd_oob"}, 128'(bus1.o_rd_data), 128'd0);
    chk({tag, "_cout"}, 128'(bus1.o_cout), 128'(ec));
    chk({tag, "_ovf"}, 128'(bus1.o_overflow), 128'(eo));
  endtask

  initial begin
    logic [63:0] ra, rb;
    int          nd;
    resetn          = 1'b0;
    bus0.i_wr_valid = 1'b0; bus0.i_wr_opnd = 1'b0; bus0.i_wr_idx = '0;
    bus0.i_wr_data  = '0;   bus0.i_start   = 1'b0; bus0.i_mode_sub = 1'b0;
    bus0.i_cin      = 1'b0; bus0.i_rd_idx  = '0;
    bus1.i_wr_valid = 1'b0; bus1.i_wr_opnd = 1'b0; bus1.i_wr_idx = '0;
    bus1.i_wr_data  = '0;   bus1.i_start   = 1'b0; bus1.i_mode_sub = 1'b0;
    bus1.i_cin      = 1'b0; bus1.i_rd_idx  = '0;
    repeat (3) step();
    resetn = 1'b1;
    step();

    chk("rst_busy", 128'(bus0.o_busy), 128'd0);
    chk("rst_done", 128'(bus0.o_done), 128'd0);
    chk("rst_cout", 128'(bus0.o_cout), 128'd0);
    chk("rst_ovf",  128'(bus0.o_overflow), 128'd0);
    for (int k = 0; k < N0; k++) begin
      bus0.i_rd_idx = 1'(k);
      #1;
      chk("rst_res", 128'(bus0.o_rd_data), 128'd0);
    end

    load0(64'h00000000_FFFFFFFF, 64'h1);
    exec0(64'h00000000_FFFFFFFF, 64'h1, 1'b0, 1'b0, 1'b0, "t1_carry");
    load0(64'h7FFFFFFF_FFFFFFFF, 64'h1);
    exec0(64'h7FFFFFFF_FFFFFFFF, 64'h1, 1'b0, 1'b0, 1'b0, "t2_ovf");
    load0(64'hFFFFFFFF_FFFFFFFF, 64'hFFFFFFFF_FFFFFFFF);
    exec0(64'hFFFFFFFF_FFFFFFFF, 64'hFFFFFFFF_FFFFFFFF, 1'b0, 1'b1, 1'b0, "t3_ones");
    load0(64'h0, 64'h1);
    exec0(64'h0, 64'h1, 1'b1, 1'b0, 1'b0, "t4_borrow");
    load0(64'h5, 64'h3);
    exec0(64'h5, 64'h3, 1'b1, 1'b1, 1'b0, "t4_sub");

    load0(64'h12345678_9ABCDEF0, 64'h0FEDCBA9_87654321);
    exec0(64'h12345678_9ABCDEF0, 64'h0FEDCBA9_87654321, 1'b0, 1'b0, 1'b1, "t5_busy_ign");
    exec0(64'h12345678_9ABCDEF0, 64'h0FEDCBA9_87654321, 1'b1, 1'b0, 1'b0, "t5_b_kept");

    // Reset asserted during the second RUN cycle.
    load0(64'hFFFFFFFF_FFFFFFFF, 64'h00000000_00000003);
    bus0.i_wr_valid = 1'b1; bus0.i_wr_opnd = 1'b1; bus0.i_wr_idx = 1'b1;
    bus0.i_wr_data  = 32'h0; bus0.i_start = 1'b1; bus0.i_mode_sub = 1'b0;
    bus0.i_cin      = 1'b0;
    step();
    bus0.i_wr_valid = 1'b0; bus0.i_start = 1'b0;
    step();
    resetn = 1'b0;
    step();
    resetn = 1'b1;
    chk("t6_busy", 128'(bus0.o_busy), 128'd0);
    bus0.i_rd_idx = 1'b0;
    #1;
    chk("t6_res0", 128'(bus0.o_rd_data), 128'd0);
    nd = 0;
    for (int c = 0; c < 6; c++) begin
      if (bus0.o_done) nd++;
      step();
    end
    chk("t6_no_done", 128'(nd), 128'd0);
    exec0(64'h0, 64'h0, 1'b0, 1'b1, 1'b0, "t6_ab_zero");

    for (int i = 0; i < 10; i++) begin
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      if (i % 3 == 0) rb = ~ra;
      if (i % 4 == 1) ra[63] = ~rb[63];
      load0(ra, rb);
      exec0(ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, "rand0");
    end

    run1(24'h00FFFF, 24'h000001, 1'b0, 1'b0, "n3_carry");
    run1(24'h000000, 24'h000001, 1'b1, 1'b0, "n3_borrow");
    for (int i = 0; i < 6; i++) begin
      run1(24'($urandom), 24'($urandom), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), "rand1");
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
